e203_exu_fpu_fmac_issue: RTL and testbench

//  Issue/hold stage directly upstream of the FMAC unit. Accepts one FP op from dispatch, drives
//  the FMAC issue handshake, and keeps rs1/rs2/imm/info/itag stable until FMAC's result is consumed.

---
 rtl/e203_exu_fpu_fmac_issue.sv | 145 ++++++++++++++
 tb/tb_e203_exu_fpu_fmac_issue.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_fpu_fmac_issue.sv
// Issue/hold stage in front of the FMAC unit: accepts one FP op, holds its fields stable
// until the FMAC result is written back, drains orphaned results after a flush.
module e203_exu_fpu_fmac_issue #(
  parameter int                XLEN      = 32,
  parameter int                INFO_W    = 16,
  parameter int                ITAG_W    = 8,
  parameter logic [INFO_W-1:0] SUPP_MASK = {INFO_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              disp_i_valid,
  output logic              disp_i_ready,
  input  logic [XLEN-1:0]   disp_i_rs1,
  input  logic [XLEN-1:0]   disp_i_rs2,
  input  logic [XLEN-1:0]   disp_i_imm,
  input  logic [INFO_W-1:0] disp_i_info,
  input  logic [ITAG_W-1:0] disp_i_itag,

  input  logic              flush_pulse,

  output logic              fmac_i_valid,
  input  logic              fmac_i_ready,
  output logic [XLEN-1:0]   fmac_i_rs1,
  output logic [XLEN-1:0]   fmac_i_rs2,
  output logic [XLEN-1:0]   fmac_i_imm,
  output logic [INFO_W-1:0] fmac_i_info,
  output logic [ITAG_W-1:0] fmac_i_itag,

  input  logic              fmac_o_valid,
  output logic              fmac_o_ready,
  input  logic [XLEN-1:0]   fmac_o_wbck_wdat,

  output logic              wbck_o_valid,
  input  logic              wbck_o_ready,
  output logic [XLEN-1:0]   wbck_o_wdat,
  output logic [ITAG_W-1:0] wbck_o_itag,
  output logic              wbck_o_err,

  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN,
    ST_ERR
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic [XLEN-1:0]   imm_q;
  logic [INFO_W-1:0] info_q;
  logic [ITAG_W-1:0] itag_q;

  logic disp_hs;
  logic result_hs;
  logic supported;

  assign disp_hs   = (state == ST_IDLE) && disp_i_valid;
  assign result_hs = (state == ST_WAIT) && fmac_o_valid && wbck_o_ready;
  assign supported = |(disp_i_info & SUPP_MASK);

  // Held fields only load on an IDLE accept, so FMAC sees stable info through REQ/WAIT/DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      info_q <= '0;
      itag_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (disp_hs && !flush_pulse) begin
            rs1_q  <= disp_i_rs1;
            rs2_q  <= disp_i_rs2;
            imm_q  <= disp_i_imm;
            info_q <= disp_i_info;
            itag_q <= disp_i_itag;
            state  <= supported ? ST_REQ : ST_ERR;
          end
        end
        ST_REQ: begin
          if (fmac_i_ready) begin
            state <= flush_pulse ? ST_DRAIN : ST_WAIT;
          end else if (flush_pulse) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (result_hs) begin
            state <= ST_IDLE;
          end else if (flush_pulse) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fmac_o_valid) begin
            state <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (wbck_o_ready || flush_pulse) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign disp_i_ready = (state == ST_IDLE);
  assign fmac_i_valid = (state == ST_REQ);
  assign fmac_i_rs1   = rs1_q;
  assign fmac_i_rs2   = rs2_q;
  assign fmac_i_imm   = imm_q;
  assign fmac_i_info  = info_q;
  assign fmac_i_itag  = itag_q;

  // Result path is a zero-latency pass-through in WAIT; DRAIN swallows whatever FMAC emits.
  always_comb begin
    fmac_o_ready = 1'b0;
    wbck_o_valid = 1'b0;
    wbck_o_wdat  = '0;
    case (state)
      ST_WAIT: begin
        fmac_o_ready = wbck_o_ready;
        wbck_o_valid = fmac_o_valid;
        wbck_o_wdat  = fmac_o_wbck_wdat;
      end
      ST_DRAIN: fmac_o_ready = 1'b1;
      ST_ERR:   wbck_o_valid = 1'b1;
      default: ;
    endcase
  end

  assign wbck_o_itag = itag_q;
  assign wbck_o_err  = (state == ST_ERR);
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_e203_exu_fpu_fmac_issue.sv
// Self-checking bench for the FMAC issue stage: a scoreboard queue of expected write-backs
// plus directed cycle-level checks of the handshake, flush, error and reset behaviour.
module tb_e203_exu_fpu_fmac_issue;

  localparam int XLEN   = 32;
  localparam int INFO_W = 16;
  localparam int ITAG_W = 8;

  typedef struct packed {
    logic [XLEN-1:0]   wdat;
    logic [ITAG_W-1:0] itag;
    logic              err;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              disp_i_valid;
  logic              disp_i_ready;
  logic [XLEN-1:0]   disp_i_rs1;
  logic [XLEN-1:0]   disp_i_rs2;
  logic [XLEN-1:0]   disp_i_imm;
  logic [INFO_W-1:0] disp_i_info;
  logic [ITAG_W-1:0] disp_i_itag;
  logic              flush_pulse;
  logic              fmac_i_valid;
  logic              fmac_i_ready;
  logic [XLEN-1:0]   fmac_i_rs1;
  logic [XLEN-1:0]   fmac_i_rs2;
  logic [XLEN-1:0]   fmac_i_imm;
  logic [INFO_W-1:0] fmac_i_info;
  logic [ITAG_W-1:0] fmac_i_itag;
  logic              fmac_o_valid;
  logic              fmac_o_ready;
  logic [XLEN-1:0]   fmac_o_wbck_wdat;
  logic              wbck_o_valid;
  logic              wbck_o_ready;
  logic [XLEN-1:0]   wbck_o_wdat;
  logic [ITAG_W-1:0] wbck_o_itag;
  logic              wbck_o_err;
  logic              busy;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   fmac_issue_hs = 0;
  int   exp_issue     = 0;
  exp_t sb[$];
  exp_t mon_e;

  e203_exu_fpu_fmac_issue #(
    .XLEN     (XLEN),
    .INFO_W   (INFO_W),
    .ITAG_W   (ITAG_W),
    .SUPP_MASK(16'h0007)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .disp_i_valid    (disp_i_valid),
    .disp_i_ready    (disp_i_ready),
    .disp_i_rs1      (disp_i_rs1),
    .disp_i_rs2      (disp_i_rs2),
    .disp_i_imm      (disp_i_imm),
    .disp_i_info     (disp_i_info),
    .disp_i_itag     (disp_i_itag),
    .flush_pulse     (flush_pulse),
    .fmac_i_valid    (fmac_i_valid),
    .fmac_i_ready    (fmac_i_ready),
    .fmac_i_rs1      (fmac_i_rs1),
    .fmac_i_rs2      (fmac_i_rs2),
    .fmac_i_imm      (fmac_i_imm),
    .fmac_i_info     (fmac_i_info),
    .fmac_i_itag     (fmac_i_itag),
    .fmac_o_valid    (fmac_o_valid),
    .fmac_o_ready    (fmac_o_ready),
    .fmac_o_wbck_wdat(fmac_o_wbck_wdat),
    .wbck_o_valid    (wbck_o_valid),
    .wbck_o_ready    (wbck_o_ready),
    .wbck_o_wdat     (wbck_o_wdat),
    .wbck_o_itag     (wbck_o_itag),
    .wbck_o_err      (wbck_o_err),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [XLEN-1:0] wdat, input logic [ITAG_W-1:0] itag,
                          input logic err);
    exp_t e;
    e.wdat = wdat;
    e.itag = itag;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Presents one op in IDLE; returns one cycle later with dispatch deasserted.
  task automatic applyStimulus(input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                               input logic [XLEN-1:0] imm, input logic [INFO_W-1:0] info,
                               input logic [ITAG_W-1:0] itag);
    disp_i_valid = 1'b1;
    disp_i_rs1   = rs1;
    disp_i_rs2   = rs2;
    disp_i_imm   = imm;
    disp_i_info  = info;
    disp_i_itag  = itag;
    @(negedge clk);
    checkOutput("disp_ready_idle", disp_i_ready, 1);
    step();
    disp_i_valid = 1'b0;
  endtask

  // Write-back monitor: every result handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fmac_i_valid && fmac_i_ready) fmac_issue_hs++;
      if (wbck_o_valid && wbck_o_ready) begin
        checkOutput("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          checkOutput("wbck_wdat", wbck_o_wdat, mon_e.wdat);
          checkOutput("wbck_itag", wbck_o_itag, mon_e.itag);
          checkOutput("wbck_err", wbck_o_err, mon_e.err);
        end
      end
    end
  end

  initial begin
    rst_n            = 1'b0;
    disp_i_valid     = 1'b0;
    disp_i_rs1       = '0;
    disp_i_rs2       = '0;
    disp_i_imm       = '0;
    disp_i_info      = '0;
    disp_i_itag      = '0;
    flush_pulse      = 1'b0;
    fmac_i_ready     = 1'b0;
    fmac_o_valid     = 1'b0;
    fmac_o_wbck_wdat = '0;
    wbck_o_ready     = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_disp_ready", disp_i_ready, 1);
    checkOutput("rst_fmac_i_valid", fmac_i_valid, 0);
    checkOutput("rst_fmac_o_ready", fmac_o_ready, 0);
    checkOutput("rst_wbck_valid", wbck_o_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_held_rs1", fmac_i_rs1, 0);
    step();
    rst_n        = 1'b1;
    wbck_o_ready = 1'b1;
    step();

    // fadd with immediate FMAC accept and a result three cycles later
    fmac_i_ready = 1'b1;
    push_exp(32'h40400000, 8'h11, 1'b0);
    applyStimulus(32'h3F800000, 32'h40000000, 32'h0, 16'h0001, 8'h11);
    exp_issue++;
    @(negedge clk);
    checkOutput("t1_fmac_i_valid", fmac_i_valid, 1);
    checkOutput("t1_rs1", fmac_i_rs1, 32'h3F800000);
    checkOutput("t1_rs2", fmac_i_rs2, 32'h40000000);
    checkOutput("t1_itag", fmac_i_itag, 8'h11);
    checkOutput("t1_busy", busy, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      checkOutput("t1_wait_no_issue", fmac_i_valid, 0);
      checkOutput("t1_wait_no_wbck", wbck_o_valid, 0);
      checkOutput("t1_info_stable", fmac_i_info, 16'h0001);
    end
    step();
    fmac_o_valid     = 1'b1;
    fmac_o_wbck_wdat = 32'h40400000;
    @(negedge clk);
    checkOutput("t1_wbck_valid", wbck_o_valid, 1);
    checkOutput("t1_fmac_o_ready", fmac_o_ready, 1);
    checkOutput("t1_info_at_result", fmac_i_info, 16'h0001);
    step();
    fmac_o_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_wbck_drop", wbck_o_valid, 0);
    checkOutput("t1_idle", busy, 0);
    checkOutput("t1_issue_cnt", fmac_issue_hs, exp_issue);

    // Write-back back-pressure: FMAC result held until wbck_o_ready rises
    step();
    push_exp(32'h12345678, 8'h22, 1'b0);
    applyStimulus(32'hAAAA0001, 32'h5555_0002, 32'h7, 16'h0002, 8'h22);
    exp_issue++;
    step();
    wbck_o_ready     = 1'b0;
    fmac_o_valid     = 1'b1;
    fmac_o_wbck_wdat = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t2_fmac_o_ready_low", fmac_o_ready, 0);
      checkOutput("t2_wbck_valid", wbck_o_valid, 1);
      checkOutput("t2_rs1_held", fmac_i_rs1, 32'hAAAA0001);
      checkOutput("t2_imm_held", fmac_i_imm, 32'h7);
      step();
    end
    wbck_o_ready = 1'b1;
    @(negedge clk);
    checkOutput("t2_fmac_o_ready_high", fmac_o_ready, 1);
    step();
    fmac_o_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_idle", disp_i_ready, 1);

    // Flush in WAIT: the orphaned result is swallowed, never written back
    step();
    applyStimulus(32'h1, 32'h2, 32'h0, 16'h0004, 8'h33);
    exp_issue++;
    step();
    flush_pulse = 1'b1;
    step();
    flush_pulse = 1'b0;
    @(negedge clk);
    checkOutput("t3_drain_fmac_o_ready", fmac_o_ready, 1);
    checkOutput("t3_drain_no_wbck", wbck_o_valid, 0);
    checkOutput("t3_drain_disp_ready", disp_i_ready, 0);
    step();
    fmac_o_valid     = 1'b1;
    fmac_o_wbck_wdat = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("t3_drain_consume", fmac_o_ready, 1);
    checkOutput("t3_drain_no_wbck2", wbck_o_valid, 0);
    step();
    fmac_o_valid = 1'b0;
    @(negedge clk);
    checkOutput("t3_back_idle", disp_i_ready, 1);

    // Flush in REQ without FMAC ready: back to IDLE, no issue handshake
    step();
    fmac_i_ready = 1'b0;
    applyStimulus(32'h3, 32'h4, 32'h0, 16'h0001, 8'h44);
    flush_pulse = 1'b1;
    @(negedge clk);
    checkOutput("t4a_req_valid", fmac_i_valid, 1);
    step();
    flush_pulse = 1'b0;
    @(negedge clk);
    checkOutput("t4a_valid_drop", fmac_i_valid, 0);
    checkOutput("t4a_idle", disp_i_ready, 1);
    checkOutput("t4a_busy", busy, 0);
    step();
    checkOutput("t4a_issue_cnt", fmac_issue_hs, exp_issue);

    // Flush in REQ with FMAC ready: DRAIN, and a second flush there is ignored
    fmac_i_ready = 1'b1;
    applyStimulus(32'h5, 32'h6, 32'h0, 16'h0001, 8'h45);
    exp_issue++;
    flush_pulse = 1'b1;
    step();
    @(negedge clk);
    checkOutput("t4b_drain_fmac_o_ready", fmac_o_ready, 1);
    checkOutput("t4b_drain_busy", busy, 1);
    checkOutput("t4b_drain_no_wbck", wbck_o_valid, 0);
    step();
    flush_pulse = 1'b0;
    @(negedge clk);
    checkOutput("t4b_flush_ignored", fmac_o_ready, 1);
    checkOutput("t4b_still_busy", busy, 1);
    step();
    fmac_o_valid = 1'b1;
    step();
    fmac_o_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4b_idle", disp_i_ready, 1);
    step();
    checkOutput("t4b_issue_cnt", fmac_issue_hs, exp_issue);

    // Unsupported op: error write-back, no FMAC traffic
    wbck_o_ready = 1'b0;
    push_exp(32'h0, 8'h05, 1'b1);
    applyStimulus(32'hCAFEF00D, 32'h1, 32'h2, 16'h0100, 8'h05);
    @(negedge clk);
    checkOutput("t5_wbck_valid", wbck_o_valid, 1);
    checkOutput("t5_err", wbck_o_err, 1);
    checkOutput("t5_wdat_zero", wbck_o_wdat, 0);
    checkOutput("t5_itag", wbck_o_itag, 8'h05);
    checkOutput("t5_no_issue", fmac_i_valid, 0);
    step();
    wbck_o_ready = 1'b1;
    step();
    @(negedge clk);
    checkOutput("t5_idle", disp_i_ready, 1);
    checkOutput("t5_err_clear", wbck_o_err, 0);
    step();
    wbck_o_ready = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0, 16'h0100, 8'h06);
    flush_pulse = 1'b1;
    @(negedge clk);
    checkOutput("t5_err_before_flush", wbck_o_err, 1);
    step();
    flush_pulse = 1'b0;
    @(negedge clk);
    checkOutput("t5_flush_idle", disp_i_ready, 1);
    checkOutput("t5_flush_no_wbck", wbck_o_valid, 0);
    step();
    wbck_o_ready = 1'b1;
    checkOutput("t5_issue_cnt", fmac_issue_hs, exp_issue);

    // Asynchronous reset while waiting on FMAC
    applyStimulus(32'h9, 32'hA, 32'h0, 16'h0002, 8'h66);
    exp_issue++;
    step();
    fmac_o_valid = 1'b1;
    wbck_o_ready = 1'b0;
    #1;
    checkOutput("t6_pre_wbck_valid", wbck_o_valid, 1);
    checkOutput("t6_pre_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_disp_ready", disp_i_ready, 1);
    checkOutput("t6_fmac_i_valid", fmac_i_valid, 0);
    checkOutput("t6_fmac_o_ready", fmac_o_ready, 0);
    checkOutput("t6_wbck_valid", wbck_o_valid, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_itag_cleared", fmac_i_itag, 0);
    fmac_o_valid = 1'b0;
    step();
    rst_n        = 1'b1;
    wbck_o_ready = 1'b1;
    step();
    step();

    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("issue_cnt_final", fmac_issue_hs, exp_issue);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
